// File: rtl/wb_rr_arbiter_if.sv
// Bus bundles for the round-robin wishbone arbiter.
// wb_m_bus_if carries the packed requests of all masters plus their per-master
// grant/ack/err lines and the shared read data.
// wb_s_bus_if carries the single shared wishbone slave port.

interface wb_m_bus_if #(
    parameter int N_MASTERS = 4
);
    logic [N_MASTERS-1:0]    m_cyc_i;
    logic [N_MASTERS-1:0]    m_stb_i;
    logic [N_MASTERS-1:0]    m_we_i;
    logic [N_MASTERS*32-1:0] m_adr_i;
    logic [N_MASTERS*32-1:0] m_dat_i;
    logic [N_MASTERS*4-1:0]  m_sel_i;
    logic [N_MASTERS-1:0]    m_gnt_o;
    logic [N_MASTERS-1:0]    m_ack_o;
    logic [N_MASTERS-1:0]    m_err_o;
    logic [31:0]             m_dat_o;

    // Requesting side (the load/store/fetch units)
    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  m_gnt_o, m_ack_o, m_err_o, m_dat_o
    );

    // Arbiter side
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output m_gnt_o, m_ack_o, m_err_o, m_dat_o
    );
endinterface

interface wb_s_bus_if;
    logic        s_cyc_o;
    logic        s_stb_o;
    logic        s_we_o;
    logic [31:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic        s_err_i;

    // Arbiter side, driving the shared slave
    modport master (
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_dat_i, s_ack_i, s_err_i
    );

    // Shared slave device
    modport slave (
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output s_dat_i, s_ack_i, s_err_i
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one wishbone slave among N_MASTERS masters.
// A master keeps the bus for its whole cyc tenure; one IDLE bubble separates
// owners. A per-access watchdog turns a never-answered strobe into an err.

module wb_rr_arbiter #(
    parameter  int N_MASTERS = 4,
    parameter  int TIMEOUT   = 64,
    localparam int OWN_W     = $clog2(N_MASTERS)
) (
    input  logic             clk,
    input  logic             rstn_i,
    wb_m_bus_if.slave        m_bus,
    wb_s_bus_if.master       s_bus,
    output logic [OWN_W-1:0] owner_o,
    output logic             busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam bit               WD_EN    = (TIMEOUT > 0);
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [OWN_W:0]   N_EXT    = (OWN_W + 1)'(N_MASTERS);
    localparam logic [OWN_W-1:0] OWN_MAX  = OWN_W'(N_MASTERS - 1);

    state_e                 state_q, state_d;
    logic [OWN_W-1:0]       ptr_q, ptr_d;
    logic [OWN_W-1:0]       owner_q, owner_d;
    logic [N_MASTERS-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [31:0]            adr_a [N_MASTERS];
    logic [31:0]            dat_a [N_MASTERS];
    logic [3:0]             sel_a [N_MASTERS];

    logic                   granted;
    logic                   own_cyc;
    logic                   own_stb;
    logic                   resp;
    logic                   abort;
    logic                   stb_out;
    logic [OWN_W-1:0]       sel_idx;
    logic [OWN_W:0]         cand;

    for (genvar k = 0; k < N_MASTERS; k++) begin : g_unpack
        assign adr_a[k] = m_bus.m_adr_i[k*32 +: 32];
        assign dat_a[k] = m_bus.m_dat_i[k*32 +: 32];
        assign sel_a[k] = m_bus.m_sel_i[k*4 +: 4];
    end

    assign granted = (state_q == GRANT);
    assign own_cyc = m_bus.m_cyc_i[owner_q];
    assign own_stb = m_bus.m_stb_i[owner_q];
    assign resp    = s_bus.s_ack_i | s_bus.s_err_i;
    // A response in the last allowed cycle wins over the abort.
    assign abort   = WD_EN && granted && own_stb && !resp && (cnt_q == CNT_LAST);
    assign stb_out = granted & own_stb & ~abort;

    assign owner_o         = owner_q;
    assign busy_o          = granted;
    assign m_bus.m_gnt_o   = gnt_q;
    assign m_bus.m_dat_o   = s_bus.s_dat_i;

    // Pick the first requester at or after ptr, wrapping modulo N_MASTERS.
    always_comb begin
        sel_idx = ptr_q;
        cand    = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (OWN_W + 1)'(i);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (m_bus.m_cyc_i[cand[OWN_W-1:0]]) begin
                sel_idx = cand[OWN_W-1:0];
            end
        end
    end

    // Route the owner's request to the slave and its response back to the owner.
    always_comb begin
        s_bus.s_cyc_o = granted & own_cyc;
        s_bus.s_stb_o = stb_out;
        s_bus.s_we_o  = granted & m_bus.m_we_i[owner_q];
        s_bus.s_adr_o = granted ? adr_a[owner_q] : '0;
        s_bus.s_dat_o = granted ? dat_a[owner_q] : '0;
        s_bus.s_sel_o = granted ? sel_a[owner_q] : '0;
        m_bus.m_ack_o = '0;
        m_bus.m_err_o = '0;
        if (granted) begin
            m_bus.m_ack_o[owner_q] = s_bus.s_ack_i & ~s_bus.s_err_i & stb_out;
            m_bus.m_err_o[owner_q] = (s_bus.s_err_i & stb_out) | abort;
        end
    end

    // Next-state logic for the IDLE/GRANT controller and the watchdog.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (|m_bus.m_cyc_i) begin
                    state_d = GRANT;
                    owner_d = sel_idx;
                    gnt_d   = {{(N_MASTERS - 1){1'b0}}, 1'b1} << sel_idx;
                end
            end
            GRANT: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = (owner_q == OWN_MAX) ? '0 : owner_q + 1'b1;
                end else if (WD_EN && stb_out && !resp) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Controller state, grant and watchdog registers.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
